// File: rtl/boot_loader_ctrl_if.sv
// boot_loader_ctrl_if
//   Byte-stream, CPU-fetch and BSRAM signals of the boot loader, bundled into one interface.
//   slave  : loader side (consumes rx bytes and cpu_adr, drives the BSRAM port and status).
//   master : environment side (byte source, CPU address, BSRAM/status observer).
// Ports (signals):
//   rx_data[7:0], rx_valid, rx_ready    byte stream with valid/ready handshake
//   cpu_adr[ADDR_W-1:0]                 CPU fetch address
//   mem_ce, mem_wre, mem_ad, mem_din    BSRAM port
//   cpu_hold, load_done, load_err       CPU hold and one-cycle result pulses
interface boot_loader_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] cpu_adr;
  logic              mem_ce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [15:0]       mem_din;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport slave (
    input  rx_data, rx_valid, cpu_adr,
    output rx_ready, mem_ce, mem_wre, mem_ad, mem_din, cpu_hold, load_done, load_err
  );

  modport master (
    output rx_data, rx_valid, cpu_adr,
    input  rx_ready, mem_ce, mem_wre, mem_ad, mem_din, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
//   Receives a framed program image over a byte stream and writes it into BSRAM
//   while holding the CPU. Frame: SYNC_BYTE, N, N x (lo, hi), checksum
//   (sum of all data bytes mod 256). Words go to consecutive addresses from 0.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  boot_loader_ctrl_if.slave (byte stream, CPU address, BSRAM port, status pulses)
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, other bytes dropped
// LEN   | expecting word count N
// LO    | expecting low byte of next word
// HI    | expecting high byte of next word
// WR    | one-cycle BSRAM write, byte stream stalled
// CHK   | expecting checksum byte
module boot_loader_ctrl #(
  parameter int          ADDR_W    = 11,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [23:0] TIMEOUT   = 24'd2_700_000
) (
  input logic              clk,
  input logic              rst,
  boot_loader_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LEN, LO, HI, WR, CHK} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] load_addr, load_addr_d;
  logic [7:0]        count, count_d;
  logic [7:0]        sum, sum_d;
  logic [23:0]       tmo, tmo_d;
  logic [7:0]        lo_byte, lo_byte_d;
  logic [15:0]       din, din_d;
  logic              hold, hold_d;
  logic              done, done_d;
  logic              err, err_d;
  logic              accept;
  logic              timed;

  assign accept = bus.rx_valid && (state != WR);
  assign timed  = (state == LEN) || (state == LO) || (state == HI) || (state == CHK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_addr <= '0;
      count     <= '0;
      sum       <= '0;
      tmo       <= '0;
      lo_byte   <= '0;
      din       <= '0;
      hold      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      load_addr <= load_addr_d;
      count     <= count_d;
      sum       <= sum_d;
      tmo       <= tmo_d;
      lo_byte   <= lo_byte_d;
      din       <= din_d;
      hold      <= hold_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    load_addr_d = load_addr;
    count_d     = count;
    sum_d       = sum;
    tmo_d       = '0;
    lo_byte_d   = lo_byte;
    din_d       = din;
    hold_d      = hold;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Idle-cycle timer; an accepted byte in the case below always overrides an abort.
    if (timed && !accept) begin
      if (tmo == TIMEOUT - 24'd1) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo + 24'd1;
      end
    end

    case (state)
      IDLE: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          load_addr_d = '0;
          count_d     = '0;
          sum_d       = '0;
          hold_d      = 1'b1;
          state_d     = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          if (bus.rx_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = bus.rx_data;
            state_d = LO;
          end
        end
      end
      LO: begin
        if (accept) begin
          lo_byte_d = bus.rx_data;
          sum_d     = sum + bus.rx_data;
          state_d   = HI;
        end
      end
      HI: begin
        if (accept) begin
          // Write data is staged here so it is already stable during WR.
          din_d   = {bus.rx_data, lo_byte};
          sum_d   = sum + bus.rx_data;
          state_d = WR;
        end
      end
      WR: begin
        load_addr_d = load_addr + ADDR_W'(1);
        count_d     = count - 8'd1;
        state_d     = (count == 8'd1) ? CHK : LO;
      end
      CHK: begin
        if (accept) begin
          if (bus.rx_data == sum) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_ready  = (state != WR);
  assign bus.mem_ce    = 1'b1;
  assign bus.mem_wre   = (state == WR);
  assign bus.mem_ad    = hold ? load_addr : bus.cpu_adr;
  assign bus.mem_din   = din;
  assign bus.cpu_hold  = hold;
  assign bus.load_done = done;
  assign bus.load_err  = err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
module tb_boot_loader_ctrl;
  localparam int AW = 11;
  localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_notready = 0;
  ev_t  exp_q[$];

  // Reference state of the loader as seen from outside.
  logic          m_hold = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_din  = '0;

  boot_loader_ctrl_if #(.ADDR_W(AW)) bus ();

  boot_loader_ctrl #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(24'd16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic pop_expect(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, expected none", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        n_fail++;
        $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
      end else if (kind == EV_WR) begin
        check("wr_addr", 32'(bus.mem_ad), 32'(e.addr));
        check("wr_data", 32'(bus.mem_din), 32'(e.data));
      end
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.rx_ready) n_notready++;
      check("ready_only_outside_wr", 32'(bus.rx_ready), 32'(!bus.mem_wre));
      if (bus.load_done && bus.load_err) check("done_err_exclusive", 32'd1, 32'd0);
      if (bus.mem_wre)   pop_expect(EV_WR);
      if (bus.load_done) pop_expect(EV_DONE);
      if (bus.load_err)  pop_expect(EV_ERR);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    g = 0;
    while (!bus.rx_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("rx_ready_stuck", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
    end
  endtask

  task automatic check_outputs(input string tag);
    @(negedge clk);
    bus.cpu_adr = AW'($urandom);
    #1;
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(m_hold));
    check({tag, "_mem_ad"}, 32'(bus.mem_ad), m_hold ? 32'(m_addr) : 32'(bus.cpu_adr));
    check({tag, "_mem_din"}, 32'(bus.mem_din), 32'(m_din));
  endtask

  // Sends a whole frame; chk_delta = 0 gives a correct checksum.
  task automatic send_frame(input logic [15:0] ws[$], input logic [7:0] chk_delta, input int gapmax);
    logic [7:0] sum;
    sum = 8'd0;
    send_byte(8'hA5);
    m_hold = 1'b1;
    m_addr = '0;
    idle($urandom_range(0, gapmax));
    if (ws.size() == 0) exp_q.push_back('{EV_ERR, '0, '0});
    send_byte(8'(ws.size()));
    foreach (ws[i]) begin
      exp_q.push_back('{EV_WR, AW'(i), ws[i]});
      idle($urandom_range(0, gapmax));
      send_byte(ws[i][7:0]);
      idle($urandom_range(0, gapmax));
      send_byte(ws[i][15:8]);
      sum = sum + ws[i][7:0] + ws[i][15:8];
      m_din = ws[i];
    end
    if (ws.size() != 0) begin
      exp_q.push_back('{(chk_delta == 8'd0) ? EV_DONE : EV_ERR, '0, '0});
      idle($urandom_range(0, gapmax));
      send_byte(sum + chk_delta);
      m_addr = AW'(ws.size());
      if (chk_delta == 8'd0) m_hold = 1'b0;
    end
    idle(3);
  endtask

  initial begin
    logic [15:0] ws[$];
    int cnt;
    int nr0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_adr  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.cpu_adr = AW'(11'h3C5);
    #1;
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    check("rst_mem_wre", 32'(bus.mem_wre), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_mem_din", 32'(bus.mem_din), 32'd0);
    check("rst_mem_ce", 32'(bus.mem_ce), 32'd1);
    check("rst_mem_ad", 32'(bus.mem_ad), 32'h3C5);
    @(negedge clk);
    rst = 1'b0;

    // Good frame, then same frame with a bad checksum.
    ws = '{16'h1234, 16'h5678};
    send_frame(ws, 8'd0, 2);
    check_outputs("good2");
    send_frame(ws, 8'd1, 2);
    check_outputs("badchk");

    // Zero-length frame.
    ws = '{};
    send_frame(ws, 8'd0, 0);
    check_outputs("len0");

    // Junk byte, then a one-word frame with rx_valid held throughout.
    send_byte(8'h11);
    nr0 = n_notready;
    ws = '{16'hEEFF};
    send_frame(ws, 8'd0, 0);
    check("single_stall_cycle", 32'(n_notready - nr0), 32'd1);
    check_outputs("contig");

    // SYNC value inside the payload is plain data.
    ws = '{16'hA5A5, 16'h00A5};
    send_frame(ws, 8'd0, 1);
    check_outputs("sync_in_data");

    // Randomized frames with leading junk and random gaps.
    for (int f = 0; f < 10; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) send_byte(8'($urandom_range(0, 8'hA4)));
      ws = '{};
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) ws.push_back(16'($urandom));
      send_frame(ws, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, 4);
      check_outputs("rand");
    end

    // Timeout: abort exactly 16 idle cycles after the last accepted byte.
    send_byte(8'hA5);
    send_byte(8'h03);
    exp_q.push_back('{EV_ERR, '0, '0});
    send_byte(8'h01);
    m_hold = 1'b1;
    m_addr = '0;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    cnt = 0;
    while (!bus.load_err && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_latency", 32'(cnt), 32'd16);
    idle(2);
    check_outputs("timeout");

    // Reset while the high byte is being offered: no write, CPU released.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h22;
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    m_hold = 1'b0;
    m_din  = 16'h0000;
    idle(3);
    check("rst_midload_pending", 32'(exp_q.size()), 32'd0);
    check_outputs("rst_midload");

    // Recovery after mid-load reset.
    ws = '{16'hBEEF, 16'h0102, 16'hFFFF};
    send_frame(ws, 8'd0, 3);
    check_outputs("recover");

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
